chip8_sprite_draw: RTL

CHIP8_SPRITE_DRAW -- requirements
Module: chip8_sprite_draw

---
 rtl/chip8_pkg.sv | 26 ++
 rtl/chip8_fb_ram.sv | 46 ++++
 rtl/chip8_sprite_draw.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// chip8_pkg: shared framebuffer geometry and the sprite-draw FSM state type.
// Used by chip8_fb_ram and chip8_sprite_draw.
package chip8_pkg;

  localparam int unsigned FB_W     = 64;
  localparam int unsigned FB_H     = 32;
  localparam int unsigned FB_WORDS = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ROW_ADR,
    ST_ROW_WAIT,
    ST_RD_L,
    ST_WR_L,
    ST_RD_R,
    ST_WR_R,
    ST_CLEAR,
    ST_DONE
  } draw_state_e;

  // Word index of the byte holding pixel row y, column byte xb (x[5:3]).
  function automatic logic [7:0] fb_word_adr(input logic [4:0] y, input logic [2:0] xb);
    return {y, xb};
  endfunction

endpackage

// File: rtl/chip8_fb_ram.sv
// chip8_fb_ram: 256x8 framebuffer memory.
//   Port A (clk, a_adr, a_we, a_wdata -> a_rdata): synchronous read/write,
//     read data valid one cycle after the address.
//   Port B (b_adr -> b_rdata): synchronous read-only display port.
//   Both read ports return the pre-write contents on a same-cycle collision.
//   rst_n (async, active-low) clears only the read-data registers, never the array.
module chip8_fb_ram
  import chip8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a_adr,
  input  logic       a_we,
  input  logic [7:0] a_wdata,
  output logic [7:0] a_rdata,
  input  logic [7:0] b_adr,
  output logic [7:0] b_rdata
);

  logic [7:0] mem_q [FB_WORDS];
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;

  always_comb begin
    a_rdata_d = mem_q[a_adr];
    b_rdata_d = mem_q[b_adr];
  end

  always_ff @(posedge clk) begin
    if (a_we) mem_q[a_adr] <= a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/chip8_sprite_draw.sv
// chip8_sprite_draw: CHIP-8 DXYN sprite draw and 00E0 clear engine on a
// 64x32 1-bpp framebuffer (256 x 8-bit words, MSB = leftmost pixel).
//   CLOCK_50      system clock
//   KEY0          asynchronous active-low reset (aborts any operation)
//   draw_start    one-cycle DXYN request; vx, vy, n, i_reg sampled on accept
//   clear_start   one-cycle 00E0 request (wins over draw_start)
//   ram_adr       main-RAM read address; ram_rdata returns one cycle later
//   busy/done     operation in progress / one-cycle completion pulse
//   collision     a set pixel was cleared by the last operation
//   disp_adr      display read address; disp_data returns one cycle later
// Build option: define CHIP8_CLIP_EN to clip sprites at the right and bottom
// edges instead of wrapping them.
module chip8_sprite_draw
  import chip8_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic        draw_start,
  input  logic        clear_start,
  input  logic [7:0]  vx,
  input  logic [7:0]  vy,
  input  logic [3:0]  n,
  input  logic [11:0] i_reg,
  output logic [11:0] ram_adr,
  input  logic [7:0]  ram_rdata,
  output logic        busy,
  output logic        done,
  output logic        collision,
  input  logic [7:0]  disp_adr,
  output logic [7:0]  disp_data
);

  draw_state_e state_q, state_d;
  logic [5:0]  x0_q, x0_d;
  logic [4:0]  y0_q, y0_d;
  logic [3:0]  n_q, n_d;
  logic [11:0] i_q, i_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  sprite_q, sprite_d;
  logic [7:0]  clr_adr_q, clr_adr_d;
  logic        coll_q, coll_d;

  logic [7:0]  fb_adr, fb_wdata, fb_rdata;
  logic        fb_we;

  logic [15:0] shifted;
  logic [7:0]  left_pat, right_pat;
  logic [5:0]  y_sum;
  logic [7:0]  left_adr, right_adr;
  logic        row_ok, right_ok;
  logic        unused_bits;

  // One 16-bit shift yields both halves: the upper byte lands in the left
  // word, the bits pushed past it land in the next column byte.
  assign shifted   = {sprite_q, 8'h00} >> x0_q[2:0];
  assign left_pat  = shifted[15:8];
  assign right_pat = shifted[7:0];

  assign y_sum     = {1'b0, y0_q} + {2'b00, row_q};
  assign left_adr  = fb_word_adr(y_sum[4:0], x0_q[5:3]);
  assign right_adr = fb_word_adr(y_sum[4:0], x0_q[5:3] + 3'd1);

`ifdef CHIP8_CLIP_EN
  // Rows past y=31 and the right byte of column byte 7 lie off-screen.
  assign row_ok   = ~y_sum[5];
  assign right_ok = row_ok & (x0_q[5:3] != 3'd7);
`else
  assign row_ok   = 1'b1;
  assign right_ok = 1'b1;
`endif

  assign unused_bits = ^{vx[7:6], vy[7:5], y_sum[5]};

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    n_d       = n_q;
    i_d       = i_q;
    row_d     = row_q;
    sprite_d  = sprite_q;
    clr_adr_d = clr_adr_q;
    coll_d    = coll_q;
    fb_adr    = '0;
    fb_we     = 1'b0;
    fb_wdata  = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (clear_start) begin
          state_d   = ST_CLEAR;
          clr_adr_d = '0;
          coll_d    = 1'b0;
        end else if (draw_start) begin
          x0_d    = vx[5:0];
          y0_d    = vy[4:0];
          n_d     = n;
          i_d     = i_reg;
          row_d   = '0;
          coll_d  = 1'b0;
          state_d = (n == 4'd0) ? ST_DONE : ST_ROW_ADR;
        end
      end
      ST_ROW_ADR:  state_d = ST_ROW_WAIT;
      ST_ROW_WAIT: begin
        sprite_d = ram_rdata;
        state_d  = ST_RD_L;
      end
      ST_RD_L: begin
        fb_adr  = left_adr;
        state_d = ST_WR_L;
      end
      ST_WR_L: begin
        fb_adr   = left_adr;
        fb_wdata = fb_rdata ^ left_pat;
        fb_we    = row_ok;
        if (row_ok && (|(fb_rdata & left_pat))) coll_d = 1'b1;
        state_d  = ST_RD_R;
      end
      ST_RD_R: begin
        fb_adr  = right_adr;
        state_d = ST_WR_R;
      end
      ST_WR_R: begin
        fb_adr   = right_adr;
        fb_wdata = fb_rdata ^ right_pat;
        fb_we    = right_ok;
        if (right_ok && (|(fb_rdata & right_pat))) coll_d = 1'b1;
        if (row_q == n_q - 4'd1) begin
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + 4'd1;
          state_d = ST_ROW_ADR;
        end
      end
      ST_CLEAR: begin
        fb_adr    = clr_adr_q;
        fb_we     = 1'b1;
        fb_wdata  = '0;
        clr_adr_d = clr_adr_q + 8'd1;
        if (clr_adr_q == 8'hFF) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q   <= ST_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      n_q       <= '0;
      i_q       <= '0;
      row_q     <= '0;
      sprite_q  <= '0;
      clr_adr_q <= '0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      n_q       <= n_d;
      i_q       <= i_d;
      row_q     <= row_d;
      sprite_q  <= sprite_d;
      clr_adr_q <= clr_adr_d;
      coll_q    <= coll_d;
    end
  end

  // Only meaningful in ROW_ADR; both terms are zero under reset.
  assign ram_adr   = i_q + {8'h00, row_q};
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign collision = coll_q;

  chip8_fb_ram u_fb (
    .clk     (CLOCK_50),
    .rst_n   (KEY0),
    .a_adr   (fb_adr),
    .a_we    (fb_we),
    .a_wdata (fb_wdata),
    .a_rdata (fb_rdata),
    .b_adr   (disp_adr),
    .b_rdata (disp_data)
  );

endmodule
